// File: rtl/i2s_sample_tx_pkg.sv
// Shared audio constants and types for the player, codec and I2S transmit blocks.
package i2s_sample_tx_pkg;

    localparam int SAMPLE_WIDTH   = 16;
    localparam int BITS_PER_FRAME = 32;
    localparam int BIT_IDX_W      = $clog2(BITS_PER_FRAME);

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_e;

endpackage

// File: rtl/i2s_sample_tx_if.sv
// Sample-source handshake plus I2S serial outputs of the transmitter.
interface i2s_sample_tx_if;
    import i2s_sample_tx_pkg::*;

    logic    enable;
    sample_t sample_in;
    logic    sample_valid;
    logic    new_frame;
    logic    underrun;
    logic    bclk;
    logic    lrclk;
    logic    sdata;

    modport master (
        output enable, sample_in, sample_valid,
        input  new_frame, underrun, bclk, lrclk, sdata
    );

    modport slave (
        input  enable, sample_in, sample_valid,
        output new_frame, underrun, bclk, lrclk, sdata
    );

endinterface

// File: rtl/i2s_sample_tx_bclk_divider.sv
// Bit-clock divider: BCLK_DIV clk cycles per bclk half-period, held at zero while not running.
module bclk_divider #(
    parameter int BCLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic bclk_o,
    output logic fall_o
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_TC = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          toggle;

    always_comb begin
        toggle = run_i && (div_q == DIV_TC);
        fall_o = toggle && bclk_q;
        div_d  = '0;
        bclk_d = 1'b0;
        if (run_i) begin
            div_d  = toggle ? '0 : div_q + DW'(1);
            bclk_d = bclk_q ^ toggle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;

endmodule

// File: rtl/i2s_sample_tx.sv
// Mono-duplicating I2S transmitter, left-justified 2x16-bit frames.
// state    | meaning
// ST_IDLE  | outputs low, counters held at 0, waits for enable
// ST_RUN   | sending frames back to back while enable is high
// ST_DRAIN | enable dropped mid-frame; finish this frame, start no new one
module i2s_sample_tx
    import i2s_sample_tx_pkg::*;
#(
    parameter int BCLK_DIV = 8
) (
    input  logic           clk,
    input  logic           reset,
    i2s_sample_tx_if.slave tx
);
    tx_state_e            state_q;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    sample_t              hold_q, word_q;
    logic                 fresh_q, started_q;
    logic                 new_frame_q, underrun_q, lrclk_q, sdata_q;
    logic                 run, bclk, fall, frame_end, start;

    bclk_divider #(.BCLK_DIV(BCLK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .run_i  (run),
        .bclk_o (bclk),
        .fall_o (fall)
    );

    always_comb begin
        run       = (state_q != ST_IDLE);
        bit_d     = bit_q + BIT_IDX_W'(1);
        frame_end = fall && (bit_q == BIT_IDX_W'(BITS_PER_FRAME - 1));
        start     = tx.enable && ((state_q == ST_IDLE) || (state_q == ST_RUN && frame_end));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            hold_q      <= '0;
            word_q      <= '0;
            fresh_q     <= 1'b0;
            started_q   <= 1'b0;
            new_frame_q <= 1'b0;
            underrun_q  <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
        end else begin
            new_frame_q <= 1'b0;
            underrun_q  <= 1'b0;

            // A sample landing on a frame start counts as fresh for the next frame.
            if (tx.sample_valid) begin
                hold_q  <= tx.sample_in;
                fresh_q <= 1'b1;
            end else if (start) begin
                fresh_q <= 1'b0;
            end

            if (start) begin
                state_q     <= ST_RUN;
                new_frame_q <= 1'b1;
                underrun_q  <= started_q && !fresh_q;
                started_q   <= 1'b1;
                word_q      <= hold_q;
                bit_q       <= '0;
                lrclk_q     <= 1'b0;
                sdata_q     <= hold_q[SAMPLE_WIDTH-1];
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_RUN: begin
                        if (frame_end)       state_q <= ST_IDLE;
                        else if (!tx.enable) state_q <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (frame_end) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase

                if (frame_end) begin
                    bit_q   <= '0;
                    lrclk_q <= 1'b0;
                    sdata_q <= 1'b0;
                end else if (fall) begin
                    bit_q   <= bit_d;
                    lrclk_q <= bit_d[BIT_IDX_W-1];
                    sdata_q <= word_q[~bit_d[BIT_IDX_W-2:0]];
                end
            end
        end
    end

    assign tx.new_frame = new_frame_q;
    assign tx.underrun  = underrun_q;
    assign tx.bclk      = bclk;
    assign tx.lrclk     = lrclk_q;
    assign tx.sdata     = sdata_q;

endmodule
